// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles the receiver's serial input and decoded-word outputs.
// Optional macro: UART_RX_PARITY_EN adds the parityError strobe.
//
// Handshake: there is no ready. dataValid, frameError (and parityError) are
// single-cycle strobes that are mutually exclusive; a consumer must capture
// `data` in the cycle dataValid is high. `data` holds between frames.
interface uart_rx_if #(
  parameter int DataBits = 8
);
  logic                rx;
  logic [DataBits-1:0] data;
  logic                dataValid;
  logic                frameError;
  logic                busy;
  logic [2:0]          state;   // receiver FSM state, for observation only
`ifdef UART_RX_PARITY_EN
  logic                parityError;
`endif

  // master: the receiver itself
  modport master (
    input  rx,
    output data, dataValid, frameError, busy, state
`ifdef UART_RX_PARITY_EN
    , output parityError
`endif
  );

  // slave: the line driver / downstream consumer
  modport slave (
    output rx,
    input  data, dataValid, frameError, busy, state
`ifdef UART_RX_PARITY_EN
    , input parityError
`endif
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 (configurable data width) UART receiver, LSB first, idle-high.
// Optional macro: UART_RX_PARITY_EN inserts an even-parity bit after the data.
module uart_rx #(
  parameter int ClockFrequency = 1000000,
  parameter int BaudRate       = 9600,
  parameter int DataBits       = 8
) (
  input  logic      clock,
  input  logic      reset,
  uart_rx_if.master bus
);
  localparam int BIT_CLKS  = ClockFrequency / BaudRate;
  localparam int HALF_CLKS = BIT_CLKS / 2;
  localparam int CW        = $clog2(BIT_CLKS) + 1;
  localparam int IW        = $clog2(DataBits);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CLKS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DataBits - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t              state;
  logic                rx_meta;
  logic                rx_s;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [DataBits-1:0] shift;
  logic [DataBits-1:0] data_q;
  logic                data_valid_q;
  logic                frame_error_q;
`ifdef UART_RX_PARITY_EN
  logic                parity_bit;
  logic                parity_error_q;
`endif

  // Two-flop synchronizer; idle-high line so both flops reset to 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM: bit timing, data shift register and the output strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      shift          <= '0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit     <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      data_valid_q   <= 1'b0;
      frame_error_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Re-check the line at mid start bit to reject glitches.
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[DataBits-1:1]};
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            parity_bit <= rx_s;
            state      <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch the next start.
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if ((^shift) ^ parity_bit) begin
                parity_error_q <= 1'b1;
              end else begin
                data_q       <= shift;
                data_valid_q <= 1'b1;
              end
`else
              data_q       <= shift;
              data_valid_q <= 1'b1;
`endif
            end else begin
              frame_error_q <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // A held-low line must return high before a new frame is accepted.
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.dataValid  = data_valid_q;
  assign bus.frameError = frame_error_q;
  assign bus.busy       = (state != IDLE);
  assign bus.state      = state;
`ifdef UART_RX_PARITY_EN
  assign bus.parityError = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; a monitor checks every strobe
// against an expected queue (kind, data, latency from the start edge).
module tb_uart_rx;
  localparam int BIT  = 16;
  localparam int HALF = 8;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + HALF + 10 * BIT + 1;
`else
  localparam int LAT = 2 + HALF + 9 * BIT + 1;
`endif
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  logic clock;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  logic [7:0] model_data;

  logic [9:0] exp_q[$];
  int         start_q[$];

  uart_rx_if #(.DataBits(8)) bus ();

  uart_rx #(
    .ClockFrequency(16),
    .BaudRate(1),
    .DataBits(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // clock / cycle counter
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    logic [1:0] kind;
    kind = K_VALID;
    if (!stop_bit) kind = K_FERR;
`ifdef UART_RX_PARITY_EN
    else if ((^d) ^ par_bit) kind = K_PERR;
`endif
    exp_q.push_back({kind, d});
    start_q.push_back(cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`else
    if (par_bit === 1'bx) $display("note: parity bit unused");
`endif
    drive_bit(stop_bit);
    bus.rx = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
      exp_q.delete();
      start_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [9:0] e;
    int         s;
    int         lat;
    logic [1:0] act_kind;
    if (reset) begin
      model_data = 8'h00;
    end else begin
      if (bus.dataValid && bus.frameError) begin
        errors++;
        $display("FAIL strobe_exclusive: dataValid=1 frameError=1 required one-hot");
      end
      act_kind = bus.dataValid ? K_VALID : (bus.frameError ? K_FERR : K_PERR);
      if (bus.dataValid || bus.frameError
`ifdef UART_RX_PARITY_EN
          || bus.parityError
`endif
          ) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: kind=%0d data=0x%0h required=none", act_kind, bus.data);
        end else begin
          e   = exp_q.pop_front();
          s   = start_q.pop_front();
          lat = cyc - s;
          if (act_kind != e[9:8]) begin
            errors++;
            $display("FAIL strobe_kind: actual=%0d required=%0d", act_kind, e[9:8]);
          end
          if (e[9:8] == K_VALID) model_data = e[7:0];
          checks++;
          if (bus.data !== model_data) begin
            errors++;
            $display("FAIL strobe_data: actual=0x%0h required=0x%0h", bus.data, model_data);
          end
          checks++;
          if (lat < LAT - 2 || lat > LAT + 2) begin
            errors++;
            $display("FAIL strobe_latency: actual=%0d required=%0d+-2", lat, LAT);
          end
        end
      end else if (bus.data !== model_data) begin
        checks++;
        errors++;
        $display("FAIL data_hold: actual=0x%0h required=0x%0h", bus.data, model_data);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic saw_busy;
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    model_data = 8'h00;
    bus.rx     = 1'b1;
    reset      = 1'b1;
    repeat (3) @(negedge clock);
    check_val("reset_data", 32'(bus.data), 32'h00);
    check_val("reset_valid", 32'(bus.dataValid), 32'h0);
    check_val("reset_ferr", 32'(bus.frameError), 32'h0);
    check_val("reset_busy", 32'(bus.busy), 32'h0);
    check_val("reset_state", 32'(bus.state), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // 1: single good frame
    send_frame(8'h55, 1'b1, 1'b0);
    wait_drain();
    repeat (2) @(negedge clock);
    check_val("t1_data", 32'(bus.data), 32'h55);
    check_val("t1_busy_after", 32'(bus.busy), 32'h0);

    // 2: back-to-back frames, next start right at end of stop bit
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    wait_drain();
    check_val("t2_data", 32'(bus.data), 32'h00);

    // 3: short low glitch
    bus.rx = 1'b0;
    repeat (3) @(negedge clock);
    bus.rx = 1'b1;
    saw_busy = 1'b0;
    for (int i = 0; i < HALF + 3; i++) begin
      @(negedge clock);
      if (bus.busy) saw_busy = 1'b1;
    end
    check_val("t3_busy_seen", 32'(saw_busy), 32'h1);
    check_val("t3_busy_idle", 32'(bus.busy), 32'h0);
    check_val("t3_data", 32'(bus.data), 32'h00);
    repeat (4) @(negedge clock);

    // 4: framing error, then held-low line, then recovery
    send_frame(8'h12, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (20 * BIT) @(negedge clock);
    wait_drain();
    check_val("t4_break_busy", 32'(bus.busy), 32'h1);
    check_val("t4_data_kept", 32'(bus.data), 32'h00);
    bus.rx = 1'b1;
    repeat (BIT) @(negedge clock);
    check_val("t4_break_exit", 32'(bus.busy), 32'h0);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_drain();
    check_val("t4_data", 32'(bus.data), 32'h7E);

    // 5: reset in the middle of data bit 4 of 0xFF
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    bus.rx = 1'b1;
    repeat (HALF) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_val("t5_rst_data", 32'(bus.data), 32'h00);
    check_val("t5_rst_valid", 32'(bus.dataValid), 32'h0);
    check_val("t5_rst_ferr", 32'(bus.frameError), 32'h0);
    check_val("t5_rst_busy", 32'(bus.busy), 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2 * BIT) @(negedge clock);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_drain();
    check_val("t5_data", 32'(bus.data), 32'h3C);

`ifdef UART_RX_PARITY_EN
    // 6: parity good then parity bad
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain();
    check_val("t6_good_data", 32'(bus.data), 32'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    wait_drain();
    check_val("t6_bad_data", 32'(bus.data), 32'h07);
`endif

    repeat (BIT) @(negedge clock);
    check_val("final_busy", 32'(bus.busy), 32'h0);
    check_val("final_queue", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
